// File: rtl/half_adder_ifelse_if.sv
// Operand/result bundle for half_adder_ifelse: master drives operands and strobes,
// slave returns the combinational, registered and statistics results.
interface half_adder_ifelse_if #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
);
  logic [LANES-1:0] A;
  logic [LANES-1:0] B;
  logic             in_valid;
  logic             stats_clr;
  logic [LANES-1:0] sum;
  logic [LANES-1:0] carry;
  logic [LANES-1:0] sum_q;
  logic [LANES-1:0] carry_q;
  logic             out_valid;
  logic [CNT_W-1:0] carry_cnt;

  modport master (
    output A, B, in_valid, stats_clr,
    input  sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );

  modport slave (
    input  A, B, in_valid, stats_clr,
    output sum, carry, sum_q, carry_q, out_valid, carry_cnt
  );
endinterface

// File: rtl/half_adder_ifelse.sv
// Per-lane half adder: combinational sum/carry plus a 1-cycle registered copy, no backpressure.
// Optional saturating carry-event counter built only when HA_STATS_EN is defined.
module half_adder_ifelse #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  half_adder_ifelse_if.slave bus
);

  logic [LANES-1:0] sum_c;
  logic [LANES-1:0] carry_c;

  always_comb begin
    sum_c   = '0;
    carry_c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!bus.A[i] && !bus.B[i]) begin
        sum_c[i]   = 1'b0;
        carry_c[i] = 1'b0;
      end else if (bus.A[i] ^ bus.B[i]) begin
        sum_c[i]   = 1'b1;
        carry_c[i] = 1'b0;
      end else begin
        sum_c[i]   = 1'b0;
        carry_c[i] = 1'b1;
      end
    end
  end

  assign bus.sum   = sum_c;
  assign bus.carry = carry_c;

  logic [LANES-1:0] sum_reg_q;
  logic [LANES-1:0] carry_reg_q;
  logic             vld_q;

  // Data holds when no strobe; only the valid flag follows in_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg_q   <= '0;
      carry_reg_q <= '0;
      vld_q       <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_reg_q   <= sum_c;
        carry_reg_q <= carry_c;
      end
    end
  end

  assign bus.sum_q     = sum_reg_q;
  assign bus.carry_q   = carry_reg_q;
  assign bus.out_valid = vld_q;

`ifdef HA_STATS_EN
  localparam int SUM_W = CNT_W + $clog2(LANES + 1);
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [SUM_W-1:0] pop;
  logic [SUM_W-1:0] cnt_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + {{(SUM_W-1){1'b0}}, carry_c[i]};
    end
    cnt_sum = {{(SUM_W-CNT_W){1'b0}}, cnt_q} + pop;
    cnt_d   = cnt_q;
    // Clear has priority over a same-cycle increment.
    if (bus.stats_clr) begin
      cnt_d = '0;
    end else if (bus.in_valid) begin
      if (cnt_sum > CNT_MAX) begin
        cnt_d = {CNT_W{1'b1}};
      end else begin
        cnt_d = cnt_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.carry_cnt = cnt_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = bus.stats_clr;
  assign bus.carry_cnt    = '0;
`endif

endmodule

// File: tb/tb_half_adder_ifelse.sv
// Directed bench for half_adder_ifelse with 4 lanes and a 4-bit counter.
module tb_half_adder_ifelse;
  localparam int LANES = 4;
  localparam int CNT_W = 4;
`ifdef HA_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  half_adder_ifelse_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

  half_adder_ifelse #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  logic [3:0] va [4];
  logic [3:0] vb [4];
  logic [3:0] vs [4];
  logic [3:0] vc [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    va = '{4'h0, 4'h0, 4'hF, 4'hF};
    vb = '{4'h0, 4'hF, 4'h0, 4'hF};
    vs = '{4'h0, 4'hF, 4'hF, 4'h0};
    vc = '{4'h0, 4'h0, 4'h0, 4'hF};

    rst_n         = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.in_valid  = 1'b0;
    bus.stats_clr = 1'b0;
    #1;
    chk("rst_sum_q", bus.sum_q, 0);
    chk("rst_carry_q", bus.carry_q, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_cnt", bus.carry_cnt, 0);

    // Truth table while held in reset: combinational path must not care.
    for (int i = 0; i < 4; i++) begin
      bus.A = va[i];
      bus.B = vb[i];
      #5;
      chk($sformatf("tt_sum_%0d", i), bus.sum, vs[i]);
      chk($sformatf("tt_carry_%0d", i), bus.carry, vc[i]);
      #5;
    end
    bus.A = 4'b1100;
    bus.B = 4'b1010;
    #2;
    chk("ml_sum", bus.sum, 4'b0110);
    chk("ml_carry", bus.carry, 4'b1000);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.A        = 4'b0011;
    bus.B        = 4'b0101;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("lat_out_valid", bus.out_valid, 1);
    chk("lat_sum_q", bus.sum_q, 4'b0110);
    chk("lat_carry_q", bus.carry_q, 4'b0001);
    chk("lat_cnt", bus.carry_cnt, cexp(1));
    bus.in_valid = 1'b0;
    bus.A        = 4'b1111;
    bus.B        = 4'b0000;
    @(negedge clk);
    chk("hold_out_valid", bus.out_valid, 0);
    chk("hold_sum_q", bus.sum_q, 4'b0110);
    chk("hold_carry_q", bus.carry_q, 4'b0001);
    chk("hold_cnt", bus.carry_cnt, cexp(1));

    bus.A        = 4'b1111;
    bus.B        = 4'b1111;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", bus.out_valid, 1);
    chk("mid_carry_q", bus.carry_q, 4'b1111);
    chk("mid_cnt", bus.carry_cnt, cexp(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum_q", bus.sum_q, 0);
    chk("arst_carry_q", bus.carry_q, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_cnt", bus.carry_cnt, 0);
    chk("arst_carry", bus.carry, 4'b1111);
    bus.A = 4'b1010;
    bus.B = 4'b0000;
    #1;
    chk("arst_comb_sum", bus.sum, 4'b1010);
    chk("arst_comb_carry", bus.carry, 4'b0000);

    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    chk("rel_out_valid", bus.out_valid, 0);
    bus.A        = 4'b0001;
    bus.B        = 4'b0000;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("rel_first_vld", bus.out_valid, 1);
    chk("rel_sum_q", bus.sum_q, 4'b0001);
    chk("rel_cnt", bus.carry_cnt, 0);

    // Back-to-back full-carry samples drive the counter into saturation.
    bus.A = 4'b1111;
    bus.B = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("sat_cnt_%0d", k), bus.carry_cnt, cexp((4 * k > 15) ? 15 : 4 * k));
      chk($sformatf("b2b_vld_%0d", k), bus.out_valid, 1);
    end

    bus.stats_clr = 1'b1;
    @(negedge clk);
    chk("clr_wins", bus.carry_cnt, 0);
    bus.stats_clr = 1'b0;
    @(negedge clk);
    chk("post_clr_cnt", bus.carry_cnt, cexp(4));
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_cnt", bus.carry_cnt, cexp(4));
    chk("idle_vld", bus.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
